wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Write-back end of the EX result interface. Accepts EX results (wd/wreg/wdata) over a
//  valid/ready handshake into a 2-entry commit queue, retires them into a 32x32 GPR file
//  one per cycle, and serves the two ID-stage operand read ports with full bypass of
//  queued (not yet retired) results. Sits between EX and ID in the CPU pipeline.
// PARAMETERS
//  DATA_W   32  register / result width
//  ADDR_W   5   register address width; file holds 2**ADDR_W registers
//  QDEPTH   2   commit queue depth (fixed 2; other values unsupported)
// PORTS
//  clk_i        in   1       clock, all state on rising edge
//  rst_i        in   1       reset, asynchronous, active-low
//  ex_valid_i   in   1       EX presents a result this cycle
//  ex_ready_o   out  1       queue can accept; transfer when ex_valid_i & ex_ready_o
//  wd_i         in   ADDR_W  destination register of EX result
//  wreg_i       in   1       result writes a register (0 = no-op entry, still queued)
//  wdata_i      in   DATA_W  EX result value
//  stall_i      in   1       hold retirement this cycle (queue keeps accepting if not full)
//  re1_i        in   1       read port 1 enable
//  raddr1_i     in   ADDR_W  read port 1 address
//  rdata1_o     out  DATA_W  read port 1 data (combinational)
//  re2_i        in   1       read port 2 enable
//  raddr2_i     in   ADDR_W  read port 2 address
//  rdata2_o     out  DATA_W  read port 2 data (combinational)
//  commit_o     out  1       pulse: an entry retired this cycle
//  commit_wd_o  out  ADDR_W  address of retired entry (valid with commit_o)
//  pending_o    out  2       queue occupancy 0..2
// BEHAVIOUR
//  - Reset (rst_i=0, async): all GPRs=0, queue empty, pending_o=0, commit_o=0,
//    commit_wd_o=0, ex_ready_o=0 while asserted; ex_ready_o=1 first cycle after release.
//  - ex_ready_o = (pending_o < 2), registered-state only; no path from ex_valid_i/stall_i.
//  - Queue is in-order FIFO. Accept: push {wd_i,wreg_i,wdata_i} at tail on handshake.
//  - Retire: if !stall_i and queue non-empty, pop head; if head.wreg && head.wd!=0 write
//    GPR[head.wd]=head.wdata at the edge. commit_o/commit_wd_o registered, high the cycle
//    after the pop edge, for one cycle per retired entry (including wreg=0 entries).
//  - Same-cycle push and pop: both occur; occupancy unchanged. Push when full impossible.
//  - Latency: accepted entry into empty queue, stall_i=0 -> GPR updated at the next edge
//    (1 cycle); visible in file on the cycle after.
//  - Reads, per port, priority: re=0 -> 0; addr==0 -> 0; youngest queued entry with
//    wreg=1 and wd==addr -> its wdata; else GPR[addr]. A result offered on ex_valid_i
//    but not yet accepted is NOT bypassed.
//  - Two queued entries to same wd: read returns the younger; both retire in order,
//    so final GPR holds the younger value.
//  - Writes to R0 are queued and retired (commit_o pulses) but never change R0.
//  - stall_i held indefinitely: queue fills to 2, ex_ready_o=0, reads still bypass.
//  - Reset mid-operation: queued entries discarded, no partial GPR write.
// TESTING
//  1. Reset release -> ex_ready_o=1, pending_o=0, rdata1_o(raddr 5)=0.
//  2. Push wd=3,wdata=0xDEADBEEF, stall_i=0 -> next edge GPR3 written, commit_o=1,
//     commit_wd_o=3; read r3 =0xDEADBEEF from cycle of acceptance onward.
//  3. stall_i=1, push wd=4/0x11 then wd=4/0x22 -> pending_o=2, ex_ready_o=0, read r4=0x22;
//     drop stall -> two commit pulses, GPR4=0x22, ex_ready_o=1 after first pop.
//  4. Push wd=0,wdata=0xFFFFFFFF,wreg=1 -> commit_o pulses, read r0=0 on both ports.
//  5. Full queue, ex_valid_i=1, stall_i 1->0 -> no push on the pop cycle (ready=0),
//     push accepted next cycle; no entry lost or duplicated (scoreboard check).
//  6. Assert rst_i low with 2 entries queued -> pending_o=0 immediately, GPRs all 0,
//     no commit_o pulse after release.

Source files
------------

// File: rtl/wb_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Purpose  : Write-back stage register file. EX results are accepted over a
//            valid/ready handshake into a two-entry in-order commit queue.
//            The queue retires one entry per cycle into a 2**ADDR_W x DATA_W
//            GPR file. Two ID-stage read ports bypass results that are queued
//            but not yet retired.
// Ports    : clk_i / rst_i (async, active-low)
//            ex_valid_i, ex_ready_o, wd_i, wreg_i, wdata_i  - EX result input
//            stall_i                                        - hold retirement
//            re1_i, raddr1_i, rdata1_o                      - read port 1
//            re2_i, raddr2_i, rdata2_o                      - read port 2
//            commit_o, commit_wd_o                          - retire pulse
//            pending_o                                      - queue occupancy
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int QDEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              stall_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic              commit_o,
    output logic [ADDR_W-1:0] commit_wd_o,
    output logic [1:0]        pending_o
);

    localparam int         c_NREGS = 2 ** ADDR_W;
    localparam logic [1:0] c_FULL  = 2'(QDEPTH);

    // Two-slot circular queue: r_head points at the oldest entry, and the
    // younger entry (when present) always lives in the other slot.
    logic [ADDR_W-1:0] r_q_wd    [2];
    logic              r_q_wreg  [2];
    logic [DATA_W-1:0] r_q_wdata [2];
    logic              r_head;
    logic [1:0]        r_count;

    logic [DATA_W-1:0] r_gpr [c_NREGS];

    logic              r_commit;
    logic [ADDR_W-1:0] r_commit_wd;

    logic w_push;
    logic w_pop;
    logic w_tail;
    logic w_young;

    // Ready depends on registered occupancy only; reset forces it low so EX
    // cannot hand over a result while the queue is being cleared.
    assign ex_ready_o = rst_i & (r_count != c_FULL);
    assign w_push     = ex_valid_i & ex_ready_o;
    assign w_pop      = ~stall_i & (r_count != 2'd0);
    assign w_tail     = r_head ^ r_count[0];
    assign w_young    = ~r_head;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_head      <= 1'b0;
            r_count     <= 2'd0;
            r_commit    <= 1'b0;
            r_commit_wd <= '0;
            for (int i = 0; i < 2; i++) begin
                r_q_wd[i]    <= '0;
                r_q_wreg[i]  <= 1'b0;
                r_q_wdata[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_q_wd[w_tail]    <= wd_i;
                r_q_wreg[w_tail]  <= wreg_i;
                r_q_wdata[w_tail] <= wdata_i;
            end
            if (w_pop) begin
                r_head      <= ~r_head;
                r_commit_wd <= r_q_wd[r_head];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            r_commit <= w_pop;
        end
    end

    // R0 is hard-wired to zero, so writes to it are simply dropped.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < c_NREGS; i++) begin
                r_gpr[i] <= '0;
            end
        end else if (w_pop && r_q_wreg[r_head] && (r_q_wd[r_head] != '0)) begin
            r_gpr[r_q_wd[r_head]] <= r_q_wdata[r_head];
        end
    end

    // Read with bypass: the younger queued match overrides the older, which
    // overrides the file; disabled ports and R0 always read zero.
    function automatic logic [DATA_W-1:0] read_port(input logic re,
                                                    input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] v;
        v = r_gpr[addr];
        if ((r_count != 2'd0) && r_q_wreg[r_head] && (r_q_wd[r_head] == addr)) begin
            v = r_q_wdata[r_head];
        end
        if ((r_count == 2'd2) && r_q_wreg[w_young] && (r_q_wd[w_young] == addr)) begin
            v = r_q_wdata[w_young];
        end
        if (!re || (addr == '0)) begin
            v = '0;
        end
        return v;
    endfunction

    always_comb begin
        rdata1_o = read_port(re1_i, raddr1_i);
        rdata2_o = read_port(re2_i, raddr2_i);
    end

    assign commit_o    = r_commit;
    assign commit_wd_o = r_commit_wd;
    assign pending_o   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Purpose  : Self-checking bench for wb_regfile. A queue-and-array reference
//            model tracks accepted results, retirement and register contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic        ex_ready_o;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic        stall_i = 1'b0;
    logic        re1_i = 1'b0;
    logic [4:0]  raddr1_i = '0;
    logic [31:0] rdata1_o;
    logic        re2_i = 1'b0;
    logic [4:0]  raddr2_i = '0;
    logic [31:0] rdata2_o;
    logic        commit_o;
    logic [4:0]  commit_wd_o;
    logic [1:0]  pending_o;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .QDEPTH(2)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ex_valid_i (ex_valid_i),
        .ex_ready_o (ex_ready_o),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .stall_i    (stall_i),
        .re1_i      (re1_i),
        .raddr1_i   (raddr1_i),
        .rdata1_o   (rdata1_o),
        .re2_i      (re2_i),
        .raddr2_i   (raddr2_i),
        .rdata2_o   (rdata2_o),
        .commit_o   (commit_o),
        .commit_wd_o(commit_wd_o),
        .pending_o  (pending_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_gpr [32];
    logic        m_commit;
    logic [4:0]  m_commit_wd;

    int n_vec = 0;
    int n_err = 0;

    function automatic void model_reset();
        m_q.delete();
        for (int i = 0; i < 32; i++) m_gpr[i] = '0;
        m_commit    = 1'b0;
        m_commit_wd = '0;
    endfunction

    function automatic logic [31:0] exp_read(input logic re, input logic [4:0] a);
        if (!re || a == 5'd0) return 32'd0;
        for (int i = m_q.size() - 1; i >= 0; i--)
            if (m_q[i].wreg && m_q[i].wd == a) return m_q[i].wdata;
        return m_gpr[a];
    endfunction

    task automatic set_in(input logic v, input logic [4:0] wd, input logic wr,
                          input logic [31:0] d, input logic st);
        ex_valid_i = v; wd_i = wd; wreg_i = wr; wdata_i = d; stall_i = st;
    endtask

    task automatic set_rd(input logic e1, input logic [4:0] a1,
                          input logic e2, input logic [4:0] a2);
        re1_i = e1; raddr1_i = a1; re2_i = e2; raddr2_i = a2;
    endtask

    // Advance one clock, applying the edge's effect to the model from the
    // inputs presented before the edge. Returns 1 ns after the falling edge.
    task automatic tick();
        logic pop, push;
        ent_t e, n;
        pop  = !stall_i && m_q.size() > 0;
        push = ex_valid_i && m_q.size() < 2;
        n.wd = wd_i; n.wreg = wreg_i; n.wdata = wdata_i;
        m_commit = pop;
        if (pop) begin
            e = m_q.pop_front();
            m_commit_wd = e.wd;
            if (e.wreg && e.wd != 5'd0) m_gpr[e.wd] = e.wdata;
        end
        if (push) m_q.push_back(n);
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        rst_i = 1'b0;
        #2;
        n_vec++; if (ex_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %0b want 0", ex_ready_o); end
        n_vec++; if (pending_o !== 2'd0) begin n_err++; $display("FAIL rst_pending: got %0d want 0", pending_o); end
        n_vec++; if (commit_o !== 1'b0) begin n_err++; $display("FAIL rst_commit: got %0b want 0", commit_o); end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        set_in(0, 0, 0, 0, 0);
        set_rd(1, 5, 1, 5);
        #1;
        n_vec++; if (ex_ready_o !== 1'b1) begin n_err++; $display("FAIL rel_ready: got %0b want 1", ex_ready_o); end
        n_vec++; if (pending_o !== 2'd0) begin n_err++; $display("FAIL rel_pending: got %0d want 0", pending_o); end
        n_vec++; if (rdata1_o !== 32'd0) begin n_err++; $display("FAIL rel_rdata1: got %h want 0", rdata1_o); end
        n_vec++; if (commit_wd_o !== 5'd0) begin n_err++; $display("FAIL rel_commit_wd: got %0d want 0", commit_wd_o); end
        tick();
    endtask

    task automatic test_single();
        set_in(1, 3, 1, 32'hDEADBEEF, 0);
        set_rd(1, 3, 0, 3);
        #1;
        n_vec++; if (ex_ready_o !== 1'b1) begin n_err++; $display("FAIL single_ready: got %0b want 1", ex_ready_o); end
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        n_vec++; if (pending_o !== 2'd1) begin n_err++; $display("FAIL single_pending: got %0d want 1", pending_o); end
        n_vec++; if (rdata1_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_bypass: got %h want deadbeef", rdata1_o); end
        n_vec++; if (rdata2_o !== 32'd0) begin n_err++; $display("FAIL single_re2_off: got %h want 0", rdata2_o); end
        tick();
        n_vec++; if (commit_o !== 1'b1 || commit_wd_o !== 5'd3) begin n_err++; $display("FAIL single_commit: got %0b/%0d want 1/3", commit_o, commit_wd_o); end
        n_vec++; if (rdata1_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_gpr: got %h want deadbeef", rdata1_o); end
        n_vec++; if (pending_o !== 2'd0) begin n_err++; $display("FAIL single_empty: got %0d want 0", pending_o); end
        tick();
        n_vec++; if (commit_o !== 1'b0) begin n_err++; $display("FAIL single_pulse: got %0b want 0", commit_o); end
    endtask

    task automatic test_same_wd();
        set_rd(1, 4, 1, 4);
        set_in(1, 4, 1, 32'h11, 1);
        tick();
        set_in(1, 4, 1, 32'h22, 1);
        tick();
        set_in(0, 0, 0, 0, 1);
        #1;
        n_vec++; if (pending_o !== 2'd2) begin n_err++; $display("FAIL same_pending: got %0d want 2", pending_o); end
        n_vec++; if (ex_ready_o !== 1'b0) begin n_err++; $display("FAIL same_ready: got %0b want 0", ex_ready_o); end
        n_vec++; if (rdata1_o !== 32'h22 || rdata2_o !== 32'h22) begin n_err++; $display("FAIL same_young: got %h/%h want 22", rdata1_o, rdata2_o); end
        stall_i = 1'b0;
        tick();
        n_vec++; if (commit_o !== 1'b1 || commit_wd_o !== 5'd4) begin n_err++; $display("FAIL same_c1: got %0b/%0d want 1/4", commit_o, commit_wd_o); end
        n_vec++; if (ex_ready_o !== 1'b1) begin n_err++; $display("FAIL same_ready1: got %0b want 1", ex_ready_o); end
        n_vec++; if (rdata1_o !== 32'h22) begin n_err++; $display("FAIL same_mid: got %h want 22", rdata1_o); end
        tick();
        n_vec++; if (commit_o !== 1'b1 || pending_o !== 2'd0) begin n_err++; $display("FAIL same_c2: got %0b/%0d want 1/0", commit_o, pending_o); end
        n_vec++; if (rdata1_o !== 32'h22) begin n_err++; $display("FAIL same_final: got %h want 22", rdata1_o); end
    endtask

    task automatic test_r0();
        set_rd(1, 0, 1, 0);
        set_in(1, 0, 1, 32'hFFFFFFFF, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        n_vec++; if (rdata1_o !== 32'd0 || rdata2_o !== 32'd0) begin n_err++; $display("FAIL r0_queued: got %h/%h want 0", rdata1_o, rdata2_o); end
        tick();
        n_vec++; if (commit_o !== 1'b1 || commit_wd_o !== 5'd0) begin n_err++; $display("FAIL r0_commit: got %0b/%0d want 1/0", commit_o, commit_wd_o); end
        n_vec++; if (rdata1_o !== 32'd0 || rdata2_o !== 32'd0) begin n_err++; $display("FAIL r0_file: got %h/%h want 0", rdata1_o, rdata2_o); end
    endtask

    task automatic test_full_release();
        set_rd(1, 7, 1, 8);
        set_in(1, 7, 1, 32'hA1, 1);
        tick();
        set_in(1, 8, 1, 32'hA2, 1);
        tick();
        set_in(1, 9, 1, 32'hA3, 1);
        #1;
        n_vec++; if (ex_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready: got %0b want 0", ex_ready_o); end
        tick();
        stall_i = 1'b0;
        #1;
        n_vec++; if (ex_ready_o !== 1'b0) begin n_err++; $display("FAIL full_popcyc_ready: got %0b want 0", ex_ready_o); end
        tick();
        n_vec++; if (ex_ready_o !== 1'b1 || pending_o !== 2'd1) begin n_err++; $display("FAIL full_after_pop: got %0b/%0d want 1/1", ex_ready_o, pending_o); end
        n_vec++; if (commit_o !== 1'b1 || commit_wd_o !== 5'd7) begin n_err++; $display("FAIL full_c7: got %0b/%0d want 1/7", commit_o, commit_wd_o); end
        tick();
        set_in(0, 0, 0, 0, 0);
        set_rd(1, 9, 1, 8);
        #1;
        n_vec++; if (pending_o !== 2'd1 || commit_wd_o !== 5'd8) begin n_err++; $display("FAIL full_c8: got %0d/%0d want 1/8", pending_o, commit_wd_o); end
        n_vec++; if (rdata1_o !== 32'hA3 || rdata2_o !== 32'hA2) begin n_err++; $display("FAIL full_reads: got %h/%h want a3/a2", rdata1_o, rdata2_o); end
        tick();
        n_vec++; if (commit_o !== 1'b1 || commit_wd_o !== 5'd9 || pending_o !== 2'd0) begin n_err++; $display("FAIL full_c9: got %0b/%0d/%0d want 1/9/0", commit_o, commit_wd_o, pending_o); end
        tick();
        n_vec++; if (commit_o !== 1'b0) begin n_err++; $display("FAIL full_nodup: got %0b want 0", commit_o); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_in($urandom_range(0, 1), 5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                   $urandom, ($urandom_range(0, 9) < 4));
            set_rd(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)),
                   ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)));
            #1;
            n_vec++; if (ex_ready_o !== (m_q.size() < 2)) begin n_err++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", n, ex_ready_o, (m_q.size() < 2)); end
            n_vec++; if (pending_o !== 2'(m_q.size())) begin n_err++; $display("FAIL rnd_pending[%0d]: got %0d want %0d", n, pending_o, m_q.size()); end
            n_vec++; if (rdata1_o !== exp_read(re1_i, raddr1_i)) begin n_err++; $display("FAIL rnd_rdata1[%0d]: got %h want %h", n, rdata1_o, exp_read(re1_i, raddr1_i)); end
            n_vec++; if (rdata2_o !== exp_read(re2_i, raddr2_i)) begin n_err++; $display("FAIL rnd_rdata2[%0d]: got %h want %h", n, rdata2_o, exp_read(re2_i, raddr2_i)); end
            n_vec++; if (commit_o !== m_commit) begin n_err++; $display("FAIL rnd_commit[%0d]: got %0b want %0b", n, commit_o, m_commit); end
            if (m_commit) begin
                n_vec++; if (commit_wd_o !== m_commit_wd) begin n_err++; $display("FAIL rnd_commit_wd[%0d]: got %0d want %0d", n, commit_wd_o, m_commit_wd); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        set_in(0, 0, 0, 0, 0);
        tick();
        tick();
        set_in(1, 10, 1, 32'h55, 1);
        tick();
        set_in(1, 11, 1, 32'h66, 1);
        tick();
        set_in(0, 0, 0, 0, 1);
        #1;
        n_vec++; if (pending_o !== 2'd2) begin n_err++; $display("FAIL mid_prefill: got %0d want 2", pending_o); end
        rst_i = 1'b0;
        #1;
        model_reset();
        n_vec++; if (pending_o !== 2'd0 || ex_ready_o !== 1'b0) begin n_err++; $display("FAIL mid_async: got %0d/%0b want 0/0", pending_o, ex_ready_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        set_in(0, 0, 0, 0, 0);
        for (int a = 0; a < 16; a++) begin
            set_rd(1, 5'(a), 1, 5'(a + 16));
            #1;
            n_vec++; if (rdata1_o !== 32'd0 || rdata2_o !== 32'd0) begin n_err++; $display("FAIL mid_gpr[%0d]: got %h/%h want 0", a, rdata1_o, rdata2_o); end
            n_vec++; if (commit_o !== 1'b0) begin n_err++; $display("FAIL mid_commit[%0d]: got %0b want 0", a, commit_o); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_same_wd();
        test_r0();
        test_full_release();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
